// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one memory command port between the cart requester (high
//            priority) and the USB requester (low priority). One command at a
//            time, at most one read outstanding, read data routed back to the
//            issuing requester, bounded USB starvation, read timeout.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int RD_TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  // cart requester
  input  logic        cart_rd_i,
  input  logic        cart_wr_i,
  input  logic [25:0] cart_addr_i,
  input  logic [1:0]  cart_width_i,
  input  logic [31:0] cart_wr_data_i,
  output logic        cart_ack_o,
  output logic [31:0] cart_rd_data_o,
  output logic        cart_rd_valid_o,
  // USB requester
  input  logic        usb_rd_i,
  input  logic        usb_wr_i,
  input  logic [25:0] usb_addr_i,
  input  logic [1:0]  usb_width_i,
  input  logic [31:0] usb_wr_data_i,
  output logic        usb_ack_o,
  output logic [31:0] usb_rd_data_o,
  output logic        usb_rd_valid_o,
  // memory side
  input  logic        mem_rd_ready_i,
  input  logic        mem_wr_ready_i,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [25:0] mem_addr_o,
  output logic [1:0]  mem_data_width_o,
  output logic [31:0] mem_wr_data_o,
  input  logic [31:0] mem_rd_data_i,
  input  logic        mem_rd_valid_i,
  // status
  output logic        busy_o,
  output logic        owner_o,
  output logic        timeout_err_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  localparam logic [SW-1:0] c_STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] c_TMO_MAX    = TW'(RD_TIMEOUT);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_WR_GAP  = 2'd1;
  localparam logic [1:0] c_RD_WAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic          mem_rd_q, mem_wr_q;
  logic [25:0]   mem_addr_q;
  logic [1:0]    mem_width_q;
  logic [31:0]   mem_wr_data_q;
  logic          cart_ack_q, usb_ack_q;
  logic          cart_rd_valid_q, usb_rd_valid_q;
  logic [31:0]   cart_rd_data_q, usb_rd_data_q;
  logic          owner_q;
  logic          timeout_err_q;

  // Issuable requests: a read beats a simultaneous write from the same master.
  logic w_cart_rd_ok, w_cart_wr_ok, w_usb_rd_ok, w_usb_wr_ok;
  logic w_cart_iss, w_usb_iss, w_usb_req, w_idle;
  logic w_grant_cart, w_grant_usb, w_grant_any, w_grant_rd;
  logic w_rd_wait, w_rsp, w_tmo, w_rd_done;

  assign w_cart_rd_ok = cart_rd_i & mem_rd_ready_i;
  assign w_cart_wr_ok = cart_wr_i & ~cart_rd_i & mem_wr_ready_i;
  assign w_usb_rd_ok  = usb_rd_i & mem_rd_ready_i;
  assign w_usb_wr_ok  = usb_wr_i & ~usb_rd_i & mem_wr_ready_i;
  assign w_cart_iss   = w_cart_rd_ok | w_cart_wr_ok;
  assign w_usb_iss    = w_usb_rd_ok | w_usb_wr_ok;
  assign w_usb_req    = usb_rd_i | usb_wr_i;
  assign w_idle       = (state_q == c_IDLE);

  // USB wins when it has been starved long enough, or when cart cannot issue.
  assign w_grant_usb  = w_idle & w_usb_iss & ((starve_q == c_STARVE_MAX) | ~w_cart_iss);
  assign w_grant_cart = w_idle & w_cart_iss & ~w_grant_usb;
  assign w_grant_any  = w_grant_usb | w_grant_cart;
  assign w_grant_rd   = w_grant_usb ? w_usb_rd_ok : w_cart_rd_ok;

  // A response in the same cycle as the timeout limit still counts as data.
  assign w_rd_wait = (state_q == c_RD_WAIT);
  assign w_rsp     = w_rd_wait & mem_rd_valid_i;
  assign w_tmo     = w_rd_wait & ~mem_rd_valid_i & (tmo_cnt_q == c_TMO_MAX);
  assign w_rd_done = w_rsp | w_tmo;

  // Next-state, starvation counter and read-wait timer.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    tmo_cnt_d = tmo_cnt_q;

    case (state_q)
      c_IDLE: begin
        if (w_grant_any) begin
          state_d = w_grant_rd ? c_RD_WAIT : c_WR_GAP;
        end
      end
      c_WR_GAP:  state_d = c_IDLE;
      c_RD_WAIT: if (w_rd_done) state_d = c_IDLE;
      default:   state_d = c_IDLE;
    endcase

    if (!w_usb_req || w_grant_usb) begin
      starve_d = '0;
    end else if (w_grant_cart && (starve_q != c_STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end

    if (w_grant_any && w_grant_rd) begin
      tmo_cnt_d = '0;
    end else if (w_rd_wait && (tmo_cnt_q != c_TMO_MAX)) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_IDLE;
      starve_q  <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Command strobes, acks, owner and the registered command payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      cart_ack_q    <= 1'b0;
      usb_ack_q     <= 1'b0;
      owner_q       <= 1'b0;
      mem_addr_q    <= '0;
      mem_width_q   <= '0;
      mem_wr_data_q <= '0;
    end else begin
      mem_rd_q   <= w_grant_any & w_grant_rd;
      mem_wr_q   <= w_grant_any & ~w_grant_rd;
      cart_ack_q <= w_grant_cart;
      usb_ack_q  <= w_grant_usb;
      if (w_grant_usb) begin
        owner_q       <= 1'b1;
        mem_addr_q    <= usb_addr_i;
        mem_width_q   <= usb_width_i;
        mem_wr_data_q <= usb_wr_data_i;
      end else if (w_grant_cart) begin
        owner_q       <= 1'b0;
        mem_addr_q    <= cart_addr_i;
        mem_width_q   <= cart_width_i;
        mem_wr_data_q <= cart_wr_data_i;
      end
    end
  end

  // Read completion: route data (or zero on timeout) to the read's owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      cart_rd_valid_q <= 1'b0;
      usb_rd_valid_q  <= 1'b0;
      cart_rd_data_q  <= '0;
      usb_rd_data_q   <= '0;
      timeout_err_q   <= 1'b0;
    end else begin
      cart_rd_valid_q <= w_rd_done & ~owner_q;
      usb_rd_valid_q  <= w_rd_done & owner_q;
      if (w_rd_done && !owner_q) begin
        cart_rd_data_q <= w_rsp ? mem_rd_data_i : 32'h0;
      end
      if (w_rd_done && owner_q) begin
        usb_rd_data_q <= w_rsp ? mem_rd_data_i : 32'h0;
      end
      if (w_tmo) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign mem_rd_o         = mem_rd_q;
  assign mem_wr_o         = mem_wr_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_data_width_o = mem_width_q;
  assign mem_wr_data_o    = mem_wr_data_q;
  assign cart_ack_o       = cart_ack_q;
  assign usb_ack_o        = usb_ack_q;
  assign cart_rd_data_o   = cart_rd_data_q;
  assign cart_rd_valid_o  = cart_rd_valid_q;
  assign usb_rd_data_o    = usb_rd_data_q;
  assign usb_rd_valid_o   = usb_rd_valid_q;
  assign busy_o           = (state_q != c_IDLE);
  assign owner_o          = owner_q;
  assign timeout_err_o    = timeout_err_q;

endmodule
`default_nettype wire
